not_gate: RTL and testbench
===========================

// Module: not_gate
// PURPOSE
//   Single-bit CMOS inverter cell. Combinational path built from one pmos and one nmos switch primitive.
//   A clocked monitor wrapper adds a registered inverted output and a saturating input-toggle counter.
//   Used as a leaf cell in logic-primitive demos and as a switch-level reference for gate characterisation.
// PARAMETERS
//   CNT_W   16   width of toggle counter edge_cnt (min 2)
// PORTS
//   clk       in   1      system clock, rising edge
//   rst       in   1      synchronous, active-high reset
//   a         in   1      inverter input
//   out       out  1      combinational inverted output, ~a
//   out_q     out  1      registered ~a, one-cycle latency
//   edge_cnt  out  CNT_W  count of sampled input transitions, saturating
//   cnt_sat   out  1      high while edge_cnt == all-ones
// BEHAVIOUR
//   Clocking and reset
//   - One clock (clk). Reset rst is synchronous and active-high.
//   Combinational path
//   - out = ~a, zero clock latency, independent of clk/rst.
//   - out tracks a within the same timestep; holds no state.
//   - Works with clk held constant.
//   - a=0 -> out=1; a=1 -> out=0.
//   - a=X or Z -> out=X (natural switch-level result; no masking).
//   Reset values (rst=1 at rising clk edge)
//   - out_q = 0
//   - a_prev (internal) = 0
//   - edge_cnt = 0
//   - cnt_sat = 0
//   - rst has priority over all other updates in that cycle.
//   Registered path (each rising clk edge, rst=0)
//   - out_q <= ~a; a_prev <= a.
//   Toggle counter
//   - If a != a_prev at the edge: edge_cnt increments by 1.
//   - Saturates at 2^CNT_W-1; never wraps.
//   - cnt_sat is combinational from edge_cnt: (edge_cnt == '1).
//   - A transition back to the same value between two edges (glitch) is not counted; sampling only.
//   - a=X/Z at an edge: no count. a_prev is loaded with X; the next known value is not counted.
//   - Reset mid-count: edge_cnt and out_q clear on that edge; counting resumes from 0 next edge.
// STRUCTURE
//   - Sub-module cmos_inv: ports a, y. Contains:
//       supply1 vdd; supply0 gnd
//       pmos (y, vdd, a); nmos (y, gnd, a)
//   - not_gate instantiates cmos_inv for out and holds the clocked monitor logic.
//   - No shared package needed. The saturation constant is local: {CNT_W{1'b1}}.
// TESTING
//   1 Combinational: a=0,1,0,1,0,1 at 5 ns steps, clk idle
//       -> out=1,0,1,0,1,0 at each step.
//   2 Reset: rst=1 for 2 edges with a=1
//       -> out_q=0, edge_cnt=0, cnt_sat=0; out=0 throughout.
//   3 Latency: after reset, a=1 then hold
//       -> out_q=0 on the first edge after the change; edge_cnt=1 then stays 1.
//   4 Toggle every cycle for 10 edges from a_prev=0
//       -> edge_cnt=10; out_q = ~a delayed one cycle.
//   5 Saturation with CNT_W=2: toggle 6 times
//       -> edge_cnt=3, cnt_sat=1, no wrap to 0.
//   6 Reset mid-count at edge_cnt=5
//       -> edge_cnt=0 next edge; a toggle after release -> edge_cnt=1.

Source files
------------

// File: rtl/not_gate_pkg.sv
// not_gate_pkg -- constants shared by the inverter cell and its clocked monitor.
//   CNT_W_DEFAULT : default width of the saturating toggle counter (minimum 2).
package not_gate_pkg;

   localparam int unsigned CNT_W_DEFAULT = 16;

endpackage : not_gate_pkg

// File: rtl/not_gate_cmos_inv.sv
// cmos_inv -- switch-level CMOS inverter built from one pmos and one nmos.
// Ports:
//   a : inverter input
//   y : inverted output. An unknown or floating input gives an unknown output.
module cmos_inv (
   input  wire a,
   output wire y
);

   supply1 vdd;
   supply0 gnd;

   // The pmos pulls y to vdd while a is low; the nmos pulls y to gnd while a is high.
   pmos p_up   (y, vdd, a);
   nmos n_down (y, gnd, a);

endmodule : cmos_inv

// File: rtl/not_gate.sv
// not_gate -- single-bit inverter cell with a clocked monitor.
//   The combinational output comes straight from the switch-level cmos_inv.
//   The monitor registers ~a and counts the sampled input transitions with a
//   saturating counter.
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous, active-high reset
//   a        : inverter input
//   out      : combinational ~a, independent of clk/rst
//   out_q    : ~a registered, one-cycle latency (0 after reset)
//   edge_cnt : number of sampled input transitions, saturating at all-ones
//   cnt_sat  : high while edge_cnt is all-ones
module not_gate
   import not_gate_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   output wire              out,
   output logic             out_q,
   output logic [CNT_W-1:0] edge_cnt,
   output logic             cnt_sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             out_q_q,    out_q_d;
   logic             a_prev_q,   a_prev_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

   cmos_inv u_inv (
      .a (a),
      .y (out)
   );

   // An unknown a (or an unknown a_prev left behind by one) makes the
   // comparison unknown, so the if-branch is not taken and nothing is counted.
   always_comb begin
      out_q_d    = ~a;
      a_prev_d   = a;
      edge_cnt_d = edge_cnt_q;
      if ((a != a_prev_q) && (edge_cnt_q != CNT_MAX)) begin
         edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q_q    <= 1'b0;
         a_prev_q   <= 1'b0;
         edge_cnt_q <= '0;
      end else begin
         out_q_q    <= out_q_d;
         a_prev_q   <= a_prev_d;
         edge_cnt_q <= edge_cnt_d;
      end
   end

   assign out_q    = out_q_q;
   assign edge_cnt = edge_cnt_q;
   assign cnt_sat  = (edge_cnt_q == CNT_MAX);

endmodule : not_gate

// File: tb/tb_not_gate.sv
// tb_not_gate -- directed bench for not_gate. Two instances share the inputs:
// the default 16-bit counter and a 2-bit counter for saturation.
module tb_not_gate;

   logic        clk;
   logic        clk_en;
   logic        rst;
   logic        a;
   wire         out16;
   wire         out2;
   logic        out_q16, out_q2;
   logic [15:0] edge_cnt16;
   logic [1:0]  edge_cnt2;
   logic        cnt_sat16, cnt_sat2;

   not_gate #(.CNT_W(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .out      (out16),
      .out_q    (out_q16),
      .edge_cnt (edge_cnt16),
      .cnt_sat  (cnt_sat16)
   );

   not_gate #(.CNT_W(2)) dut2 (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .out      (out2),
      .out_q    (out_q2),
      .edge_cnt (edge_cnt2),
      .cnt_sat  (cnt_sat2)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = clk_en ? ~clk : clk;

   // ---------------- scoreboard ----------------
   // which: 0 out, 1 out_q, 2 edge_cnt, 3 cnt_sat, 4 edge_cnt2, 5 cnt_sat2, 6 out_q2
   typedef struct {
      string       name;
      int          which;
      logic [15:0] exp;
   } exp_t;

   exp_t exp_q[$];
   event sample_ev;
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [15:0] actual(input int which);
      case (which)
         0:       return {15'b0, out16};
         1:       return {15'b0, out_q16};
         2:       return edge_cnt16;
         3:       return {15'b0, cnt_sat16};
         4:       return {14'b0, edge_cnt2};
         5:       return {15'b0, cnt_sat2};
         6:       return {15'b0, out_q2};
         default: return 16'hxxxx;
      endcase
   endfunction

   // Monitor: drains every pending expectation whenever the driver marks a sample point.
   initial begin
      exp_t        e;
      logic [15:0] act;
      forever begin
         @(sample_ev);
         while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = actual(e.which);
            n_cmp++;
            if (act !== e.exp) begin
               n_bad++;
               $display("FAIL %s: got %0h expected %0h at %0t", e.name, act, e.exp, $time);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic expect_val(input string name, input int which, input logic [15:0] exp);
      exp_t e;
      e.name  = name;
      e.which = which;
      e.exp   = exp;
      exp_q.push_back(e);
   endtask

   task automatic sample();
      -> sample_ev;
      #1;
   endtask

   // Inputs change 2 time units after a rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input logic a_val);
      rst = 1'b1;
      a   = a_val;
      tick();
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic [5:0] exp_comb;
   int         exp_sat5[6];

   initial begin
      clk_en = 1'b0;
      rst    = 1'b0;
      a      = 1'b0;

      // 1: combinational path with the clock idle
      exp_comb = 6'b010101;
      for (int i = 0; i < 6; i++) begin
         a = (i % 2 == 1);
         #5;
         expect_val("comb_out", 0, {15'b0, exp_comb[i]});
         sample();
      end

      // 2: reset held for two edges with a=1
      clk_en = 1'b1;
      a      = 1'b1;
      rst    = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         expect_val("rst_out_q", 1, 16'd0);
         expect_val("rst_edge_cnt", 2, 16'd0);
         expect_val("rst_cnt_sat", 3, 16'd0);
         expect_val("rst_out", 0, 16'd0);
         expect_val("rst_edge_cnt2", 4, 16'd0);
         sample();
      end

      // 3: release with a=1 held; first edge counts the 0->1 change only once
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_val("lat_out_q", 1, 16'd0);
         expect_val("lat_edge_cnt", 2, 16'd1);
         expect_val("lat_out", 0, 16'd0);
         sample();
      end

      // 4: toggle on every one of 10 edges from a_prev=0
      do_reset(1'b0);
      for (int i = 1; i <= 10; i++) begin
         a = (i % 2 == 1);
         tick();
         expect_val("tog_out_q", 1, {15'b0, (i % 2 == 0)});
         expect_val("tog_edge_cnt", 2, 16'(i));
      expect_val("tog_out", 0, {15'b0, (i % 2 == 0)});
         sample();
      end
      expect_val("tog_cnt_sat", 3, 16'd0);
      expect_val("tog_edge_cnt2_sat", 4, 16'd3);
      expect_val("tog_cnt_sat2", 5, 16'd1);
      sample();

      // 5: saturation of the 2-bit counter, six toggles
      exp_sat5 = '{1, 2, 3, 3, 3, 3};
      do_reset(1'b0);
      for (int i = 0; i < 6; i++) begin
         a = ~a;
         tick();
         expect_val("sat_edge_cnt2", 4, 16'(exp_sat5[i]));
         expect_val("sat_cnt_sat2", 5, {15'b0, (exp_sat5[i] == 3)});
         expect_val("sat_out_q2", 6, {15'b0, ~a});
         sample();
      end

      // glitch between edges is invisible to the counter
      a = ~a;
      #3;
      a = ~a;
      tick();
      expect_val("glitch_edge_cnt", 2, 16'd6);
      sample();

      // 6: reset in the middle of a count
      do_reset(1'b0);
      for (int i = 0; i < 5; i++) begin
         a = ~a;
         tick();
      end
      expect_val("mid_edge_cnt", 2, 16'd5);
      sample();
      rst = 1'b1;
      a   = 1'b0;
      tick();
      expect_val("mid_rst_edge_cnt", 2, 16'd0);
      expect_val("mid_rst_out_q", 1, 16'd0);
      sample();
      rst = 1'b0;
      tick();
      expect_val("mid_hold_edge_cnt", 2, 16'd0);
      expect_val("mid_hold_out_q", 1, 16'd1);
      sample();
      a = 1'b1;
      tick();
      expect_val("mid_resume_edge_cnt", 2, 16'd1);
      expect_val("mid_resume_out_q", 1, 16'd0);
      sample();

      // ---------------- report ----------------
      #5;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover_expectations: got %0d expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #100000;
      $display("FAIL timeout: got stall expected completion");
      $fatal(1, "timeout");
   end

endmodule : tb_not_gate
